// File: rtl/level_tile_fetcher.sv
// level_tile_fetcher
//   Shares one read port of the 20x15 level-tile memory (3-bit block IDs) between a
//   per-line row prefetch and game-logic lookups. During horizontal blanking the tile row
//   for the next scanline is copied into a 20-entry line buffer. The display reads
//   blockType from that buffer, so it never touches the memory port while pixels are
//   visible. Game reads get the port only when no prefetch is running.
// Ports
//   clk, reset        system clock, asynchronous active-high reset
//   hCount, vCount    VGA pixel position (hCount may hold for several clocks)
//   mem_addr/mem_data level memory port, data returned one clock after the address
//   game_req/addr     game read request, held until game_grant
//   game_grant        the game address is on mem_addr this cycle
//   game_valid/data   read result one clock after the grant; data held until the next
//   blockType         registered tile ID under (hCount, vCount), 0 outside the play area
//   fetch_busy        a row prefetch owns the memory port
module level_tile_fetcher #(
  parameter int unsigned H_START = 144,
  parameter int unsigned H_TRIG  = 784,
  parameter int unsigned V_START = 35,
  parameter int unsigned COLS    = 20,
  parameter int unsigned ROWS    = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hCount,
  input  logic [9:0] vCount,
  output logic [8:0] mem_addr,
  input  logic [2:0] mem_data,
  input  logic       game_req,
  input  logic [8:0] game_addr,
  output logic       game_grant,
  output logic       game_valid,
  output logic [2:0] game_data,
  output logic [2:0] blockType,
  output logic       fetch_busy
);

  localparam logic [9:0]  HStart   = 10'(H_START);
  localparam logic [9:0]  HEnd     = 10'(H_START + COLS * 32);
  localparam logic [9:0]  HTrig    = 10'(H_TRIG);
  localparam logic [9:0]  VStartPx = 10'(V_START);
  localparam logic [9:0]  VEndPx   = 10'(V_START + ROWS * 32);
  localparam logic [10:0] VStart   = 11'(V_START);
  localparam logic [10:0] VEnd     = 11'(V_START + ROWS * 32);
  localparam logic [8:0]  RowStep  = 9'(COLS);
  localparam logic [4:0]  LastCol  = 5'(COLS - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} stateT;

  stateT      stateQ, stateD;
  logic [4:0] colQ, colD;
  logic [8:0] baseQ, baseD;
  logic [9:0] hPrevQ;
  logic [8:0] memAddrQ;
  logic       wrEn, wrEnQ;
  logic [4:0] wrIdxQ;
  logic       grantQ;
  logic [2:0] gameDataQ;
  logic [2:0] blockTypeQ;
  logic [2:0] lineBuf [COLS];

  // Trigger: hCount has just arrived at H_TRIG and the next line starts a tile row.
  logic [10:0] nextLine;
  logic [4:0]  lineOff;
  logic        rowStart;
  logic        trigger;

  assign nextLine = {1'b0, vCount} + 11'd1;
  assign lineOff  = 5'(nextLine - VStart);
  assign rowStart = (nextLine >= VStart) && (nextLine < VEnd) && (lineOff == 5'd0);
  assign trigger  = (hCount == HTrig) && (hPrevQ != HTrig) && rowStart;

  // Pixel lookup into the line buffer.
  logic       inArea;
  logic [4:0] tileIdx;

  assign inArea  = (hCount >= HStart) && (hCount < HEnd) &&
                   (vCount >= VStartPx) && (vCount < VEndPx);
  assign tileIdx = 5'((hCount - HStart) >> 5);

  always_comb begin
    stateD     = stateQ;
    colD       = colQ;
    baseD      = baseQ;
    mem_addr   = memAddrQ;
    game_grant = 1'b0;
    wrEn       = 1'b0;
    case (stateQ)
      StIdle: begin
        if (trigger) begin
          stateD = StFetch;
          colD   = 5'd0;
          // Row base accumulates one row per prefetch; restarts at the first play line.
          baseD  = (nextLine == VStart) ? 9'd0 : baseQ + RowStep;
        end else if (game_req) begin
          mem_addr   = game_addr;
          game_grant = 1'b1;
        end
      end
      StFetch: begin
        mem_addr = baseQ + {4'd0, colQ};
        wrEn     = 1'b1;
        if (colQ == LastCol) begin
          stateD = StDrain;
        end else begin
          colD = colQ + 5'd1;
        end
      end
      StDrain: begin
        stateD = StIdle;
      end
      default: begin
        stateD = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateQ     <= StIdle;
      colQ       <= 5'd0;
      baseQ      <= 9'd0;
      hPrevQ     <= 10'd0;
      memAddrQ   <= 9'd0;
      wrEnQ      <= 1'b0;
      wrIdxQ     <= 5'd0;
      grantQ     <= 1'b0;
      gameDataQ  <= 3'd0;
      blockTypeQ <= 3'd0;
      for (int i = 0; i < int'(COLS); i++) begin
        lineBuf[i] <= 3'd0;
      end
    end else begin
      stateQ   <= stateD;
      colQ     <= colD;
      baseQ    <= baseD;
      hPrevQ   <= hCount;
      memAddrQ <= mem_addr;
      wrEnQ    <= wrEn;
      wrIdxQ   <= colQ;
      grantQ   <= game_grant;
      // Memory data lags the address by one clock, so writes and game captures use
      // the registered strobe from the issuing cycle.
      if (wrEnQ) begin
        lineBuf[wrIdxQ] <= mem_data;
      end
      if (grantQ) begin
        gameDataQ <= mem_data;
      end
      blockTypeQ <= inArea ? lineBuf[tileIdx] : 3'd0;
    end
  end

  assign fetch_busy = (stateQ != StIdle);
  assign game_valid = grantQ;
  assign game_data  = grantQ ? mem_data : gameDataQ;
  assign blockType  = blockTypeQ;

endmodule

// File: tb/tb_level_tile_fetcher.sv
module tb_level_tile_fetcher;

  logic       clk;
  logic       reset;
  logic [9:0] hCount;
  logic [9:0] vCount;
  logic [8:0] mem_addr;
  logic [2:0] mem_data;
  logic       game_req;
  logic [8:0] game_addr;
  logic       game_grant;
  logic       game_valid;
  logic [2:0] game_data;
  logic [2:0] blockType;
  logic       fetch_busy;

  level_tile_fetcher dut (
    .clk        (clk),
    .reset      (reset),
    .hCount     (hCount),
    .vCount     (vCount),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .game_req   (game_req),
    .game_addr  (game_addr),
    .game_grant (game_grant),
    .game_valid (game_valid),
    .game_data  (game_data),
    .blockType  (blockType),
    .fetch_busy (fetch_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Level memory: 300 tiles, synchronous read with one clock of latency.
  logic [2:0] mem [300];
  always @(posedge clk) begin
    mem_data <= (mem_addr < 9'd300) ? mem[mem_addr] : 3'd0;
  end

  // Reference model state: contents the line buffer should hold.
  logic [2:0] refBuf [20];
  int obsAddr [20];
  int busyCnt;
  int checks = 0;
  int passes = 0;

  function automatic logic [2:0] expBlock(int h, int v);
    if (h >= 144 && h < 144 + 20 * 32 && v >= 35 && v < 35 + 15 * 32) return refBuf[(h - 144) / 32];
    return 3'd0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < 300; i++) mem[i] = 3'($urandom);
  endtask

  // Drives one hCount edge to H_TRIG on line vLine and records the next 24 clocks.
  task automatic run_fetch(input int vLine);
    vCount = 10'(vLine);
    hCount = 10'd783;
    step();
    hCount = 10'd784;
    busyCnt = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (i < 20) obsAddr[i] = int'(mem_addr);
      if (fetch_busy) busyCnt++;
    end
  endtask

  task automatic load_ref(input int row);
    for (int k = 0; k < 20; k++) refBuf[k] = mem[row * 20 + k];
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++; if (fetch_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", fetch_busy); else passes++;
    checks++; if (game_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", game_valid); else passes++;
    checks++; if (game_data !== 3'd0) $display("FAIL reset_gdata: got %0d want 0", game_data); else passes++;
    checks++; if (blockType !== 3'd0) $display("FAIL reset_block: got %0d want 0", blockType); else passes++;
    checks++; if (mem_addr !== 9'd0) $display("FAIL reset_addr: got %0d want 0", mem_addr); else passes++;
    checks++; if (game_grant !== 1'b0) $display("FAIL reset_grant: got %b want 0", game_grant); else passes++;
    reset = 1'b0;
    for (int k = 0; k < 20; k++) refBuf[k] = 3'd0;
    step();
  endtask

  // Row 1 straight after reset, then line 67 reads it back.
  task automatic test_row_fetch();
    int hs [10];
    run_fetch(66);
    checks++; if (busyCnt !== 21) $display("FAIL row1_busy: got %0d want 21", busyCnt); else passes++;
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (obsAddr[k] !== 20 + k) $display("FAIL row1_addr[%0d]: got %0d want %0d", k, obsAddr[k], 20 + k);
      else passes++;
    end
    load_ref(1);
    hs[0] = 143; hs[1] = 144; hs[2] = 175; hs[3] = 176; hs[4] = 783;
    for (int i = 5; i < 10; i++) hs[i] = int'($urandom_range(0, 783));
    vCount = 10'd67;
    for (int i = 0; i < 10; i++) begin
      hCount = 10'(hs[i]);
      step();
      checks++;
      if (blockType !== expBlock(hs[i], 67))
        $display("FAIL row1_block h=%0d: got %0d want %0d", hs[i], blockType, expBlock(hs[i], 67));
      else passes++;
    end
  endtask

  task automatic test_row0();
    run_fetch(34);
    checks++; if (busyCnt !== 21) $display("FAIL row0_busy: got %0d want 21", busyCnt); else passes++;
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (obsAddr[k] !== k) $display("FAIL row0_addr[%0d]: got %0d want %0d", k, obsAddr[k], k);
      else passes++;
    end
    load_ref(0);
    run_fetch(35);
    checks++; if (busyCnt !== 0) $display("FAIL line35_busy: got %0d want 0", busyCnt); else passes++;
    run_fetch(36);
    checks++; if (busyCnt !== 0) $display("FAIL line36_busy: got %0d want 0", busyCnt); else passes++;
    vCount = 10'd36;
    for (int i = 0; i < 20; i++) begin
      int h;
      h = 144 + 32 * i + int'($urandom_range(0, 31));
      hCount = 10'(h);
      step();
      checks++;
      if (blockType !== expBlock(h, 36))
        $display("FAIL row0_block h=%0d: got %0d want %0d", h, blockType, expBlock(h, 36));
      else passes++;
    end
  endtask

  task automatic test_game_read();
    hCount = 10'd0;
    vCount = 10'd0;
    game_req = 1'b1;
    game_addr = 9'd299;
    #1;
    checks++; if (game_grant !== 1'b1) $display("FAIL gread_grant: got %b want 1", game_grant); else passes++;
    checks++; if (mem_addr !== 9'd299) $display("FAIL gread_addr: got %0d want 299", mem_addr); else passes++;
    step();
    game_req = 1'b0;
    #1;
    checks++; if (game_valid !== 1'b1) $display("FAIL gread_valid: got %b want 1", game_valid); else passes++;
    checks++; if (game_data !== mem[299]) $display("FAIL gread_data: got %0d want %0d", game_data, mem[299]); else passes++;
    step();
    checks++; if (game_valid !== 1'b0) $display("FAIL gread_valid_end: got %b want 0", game_valid); else passes++;
    checks++; if (game_data !== mem[299]) $display("FAIL gread_hold: got %0d want %0d", game_data, mem[299]); else passes++;
  endtask

  task automatic test_back_to_back();
    int prev;
    prev = -1;
    game_req = 1'b1;
    for (int i = 0; i < 12; i++) begin
      int a;
      a = int'($urandom_range(0, 299));
      game_addr = 9'(a);
      #1;
      checks++; if (game_grant !== 1'b1) $display("FAIL b2b_grant[%0d]: got %b want 1", i, game_grant); else passes++;
      checks++; if (mem_addr !== 9'(a)) $display("FAIL b2b_addr[%0d]: got %0d want %0d", i, mem_addr, a); else passes++;
      if (prev >= 0) begin
        checks++;
        if (game_valid !== 1'b1 || game_data !== mem[prev])
          $display("FAIL b2b_data[%0d]: got v=%b d=%0d want v=1 d=%0d", i, game_valid, game_data, mem[prev]);
        else passes++;
      end
      prev = a;
      step();
    end
    game_req = 1'b0;
    #1;
    checks++;
    if (game_valid !== 1'b1 || game_data !== mem[prev])
      $display("FAIL b2b_last: got v=%b d=%0d want v=1 d=%0d", game_valid, game_data, mem[prev]);
    else passes++;
    checks++; if (game_grant !== 1'b0) $display("FAIL b2b_idle_grant: got %b want 0", game_grant); else passes++;
    step();
  endtask

  task automatic test_collision();
    int a, grantAt, validAt, busy, gAddr, vData;
    a = int'($urandom_range(0, 299));
    grantAt = -1; validAt = -1; busy = 0; gAddr = -1; vData = -1;
    vCount = 10'd34;
    hCount = 10'd783;
    step();
    hCount = 10'd784;
    game_req = 1'b1;
    game_addr = 9'(a);
    #1;
    checks++; if (game_grant !== 1'b0) $display("FAIL coll_t0_grant: got %b want 0", game_grant); else passes++;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (grantAt >= 0 && grantAt == i - 1) game_req = 1'b0;
      if (fetch_busy) busy++;
      if (game_grant && game_req && grantAt < 0) begin
        grantAt = i;
        gAddr = int'(mem_addr);
      end
      if (game_valid && validAt < 0) begin
        validAt = i;
        vData = int'(game_data);
      end
    end
    game_req = 1'b0;
    checks++; if (busy !== 21) $display("FAIL coll_busy: got %0d want 21", busy); else passes++;
    checks++; if (grantAt !== 22) $display("FAIL coll_grant_clk: got %0d want 22", grantAt); else passes++;
    checks++; if (validAt !== 23) $display("FAIL coll_valid_clk: got %0d want 23", validAt); else passes++;
    checks++; if (gAddr !== a) $display("FAIL coll_addr: got %0d want %0d", gAddr, a); else passes++;
    checks++; if (vData !== int'(mem[a])) $display("FAIL coll_data: got %0d want %0d", vData, mem[a]); else passes++;
    load_ref(0);
  endtask

  // Whole frame of row prefetches in order, each read back on the following line.
  task automatic test_frame();
    randomize_mem();
    for (int r = 0; r < 15; r++) begin
      int vLine;
      vLine = 35 + 32 * r - 1;
      run_fetch(vLine);
      checks++; if (busyCnt !== 21) $display("FAIL frame_busy r=%0d: got %0d want 21", r, busyCnt); else passes++;
      for (int k = 0; k < 20; k++) begin
        checks++;
        if (obsAddr[k] !== r * 20 + k)
          $display("FAIL frame_addr r=%0d k=%0d: got %0d want %0d", r, k, obsAddr[k], r * 20 + k);
        else passes++;
      end
      load_ref(r);
      vCount = 10'(vLine + 1 + int'($urandom_range(0, 31)));
      for (int i = 0; i < 8; i++) begin
        int h;
        h = int'($urandom_range(100, 783));
        hCount = 10'(h);
        step();
        checks++;
        if (blockType !== expBlock(h, int'(vCount)))
          $display("FAIL frame_block r=%0d h=%0d: got %0d want %0d", r, h, blockType, expBlock(h, int'(vCount)));
        else passes++;
      end
    end
    run_fetch(514);
    checks++; if (busyCnt !== 0) $display("FAIL line514_busy: got %0d want 0", busyCnt); else passes++;
  endtask

  task automatic test_outside();
    int hs [5];
    int vs [5];
    hs[0] = 100; vs[0] = 200;
    hs[1] = 143; vs[1] = 200;
    hs[2] = 784; vs[2] = 300;
    hs[3] = 200; vs[3] = 515;
    hs[4] = 200; vs[4] = 34;
    for (int i = 0; i < 5; i++) begin
      hCount = 10'(hs[i]);
      vCount = 10'(vs[i]);
      step();
      checks++;
      if (blockType !== 3'd0) $display("FAIL outside h=%0d v=%0d: got %0d want 0", hs[i], vs[i], blockType);
      else passes++;
    end
  endtask

  task automatic test_reset_mid_fetch();
    for (int k = 0; k < 20; k++) mem[k] = 3'(1 + (k % 7));
    vCount = 10'd34;
    hCount = 10'd783;
    step();
    hCount = 10'd784;
    for (int i = 0; i < 8; i++) step();
    checks++; if (mem_addr !== 9'd7) $display("FAIL midrst_col: got %0d want 7", mem_addr); else passes++;
    reset = 1'b1;
    hCount = 10'd0;
    #1;
    checks++; if (fetch_busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", fetch_busy); else passes++;
    checks++; if (blockType !== 3'd0) $display("FAIL midrst_block: got %0d want 0", blockType); else passes++;
    checks++; if (game_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", game_valid); else passes++;
    step();
    reset = 1'b0;
    for (int k = 0; k < 20; k++) refBuf[k] = 3'd0;
    step();
    checks++; if (fetch_busy !== 1'b0) $display("FAIL midrst_busy_after: got %b want 0", fetch_busy); else passes++;
    checks++; if (game_valid !== 1'b0) $display("FAIL midrst_valid_after: got %b want 0", game_valid); else passes++;
    vCount = 10'd40;
    for (int i = 0; i < 8; i++) begin
      int h;
      h = 144 + 32 * i + 5;
      hCount = 10'(h);
      step();
      checks++;
      if (blockType !== expBlock(h, 40)) $display("FAIL midrst_buf h=%0d: got %0d want %0d", h, blockType, expBlock(h, 40));
      else passes++;
    end
  endtask

  initial begin
    reset = 1'b1;
    hCount = 10'd0;
    vCount = 10'd0;
    game_req = 1'b0;
    game_addr = 9'd0;
    randomize_mem();
    test_reset();
    test_row_fetch();
    test_row0();
    test_game_read();
    test_back_to_back();
    test_collision();
    test_frame();
    test_outside();
    test_reset_mid_fetch();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
